audio_src_arbiter: RTL and testbench
====================================

Name: audio_src_arbiter

Overview:
- Shares the audio DAC serializer between up to four sample sources (sine ROM, tone generator, line-in loopback, test pattern).
- Once per audio frame it picks one source, according to a selectable policy. It latches that source's stereo sample into the registers the serializer shifts out.
- Each source hands samples over through a valid/ready handshake into a one-entry holding register.
- The block detects and counts underruns.

Parameters:
NUM_SRC, 4, number of sources (1..4)
DATA_WIDTH, 16, bits per channel sample
HOLD_ON_UNDERRUN, 1, 1 = repeat last sample on underrun, 0 = output zero

Ports:
iCLK_18_4  in  1  18.432 MHz system clock
iRST_N  in  1  asynchronous active-low reset
iAUD_LRCK  in  1  frame clock from serializer (asynchronous to logic; synchronized internally)
iMode  in  2  0 = forced select, 1 = fixed priority, 2 = round-robin, 3 = mute
iSrc_Select  in  2  source index used in mode 0
iSrc_Valid  in  NUM_SRC  per-source sample valid
oSrc_Ready  out  NUM_SRC  per-source holding register empty
iSrc_Data  in  NUM_SRC*2*DATA_WIDTH  source k at bits [k*32+31:k*32] (defaults); layout {L,R}
oSample_L  out  DATA_WIDTH  left sample to serializer
oSample_R  out  DATA_WIDTH  right sample to serializer
oFrame_Strobe  out  1  one-cycle pulse when oSample_L/R update
oGrant_Idx  out  2  source that supplied the current sample
oGrant_Valid  out  1  1 = current sample came from a source; 0 = underrun or mute
oUnderrun  out  1  one-cycle pulse on underrun frame
oUnderrun_Cnt  out  16  saturating underrun count
iClr_Cnt  in  1  synchronous clear of oUnderrun_Cnt

Behaviour:
- Reset (async, any time, including mid-frame):
  - All holding registers are empty, so oSrc_Ready is all 1s.
  - oSample_L/R = 0, oFrame_Strobe = 0, oGrant_Idx = 0, oGrant_Valid = 0, oUnderrun = 0, oUnderrun_Cnt = 0.
  - Round-robin pointer = NUM_SRC-1.
  - The LRCK synchronizer flops are cleared.
- Handshake, per source k:
  - oSrc_Ready[k] = ~full[k].
  - When iSrc_Valid[k] && oSrc_Ready[k] at a clock edge, the data is captured and full[k] is set.
  - A full register is cleared only when it is granted. oSrc_Ready[k] rises the cycle after the grant.
  - No load and grant can occur on the same register in the same cycle.
- Frame strobe:
  - iAUD_LRCK passes through a 2-flop synchronizer, then a 3rd flop for edge detection.
  - The internal strobe is asserted for one cycle on the synchronized falling edge, which is 3 edges after the input edge.
- Arbitration is evaluated only in the strobe cycle. Outputs register on the next edge together with a 1-cycle oFrame_Strobe. iMode and iSrc_Select are sampled in the strobe cycle.
- Mode 0: grant iSrc_Select if it is < NUM_SRC and that source is full; otherwise underrun.
- Mode 1: grant the lowest index that is full.
- Mode 2:
  - Search from pointer+1 upward, wrapping modulo NUM_SRC. Grant the first full source and set pointer to it.
  - With no full source the pointer is unchanged.
- Mode 3:
  - Outputs 0, oGrant_Valid = 0.
  - No source is consumed and no underrun is flagged. oFrame_Strobe still pulses.
- Grant: oSample_L/R take the holding data, oGrant_Idx = source, oGrant_Valid = 1, and that full bit clears.
- Underrun (modes 0-2, nothing grantable):
  - Samples are held if HOLD_ON_UNDERRUN = 1, or set to 0 if it is 0.
  - oGrant_Valid = 0, oGrant_Idx is unchanged, oUnderrun pulses with oFrame_Strobe.
  - The counter increments and saturates at 16'hFFFF.
- iClr_Cnt in the same cycle as an increment: clear wins, and the counter reads 0.
- Sources other than the granted one keep their data.

Test Plan:
- Reset, then preload src0 = {16'h1111, 16'h2222}, mode 0, select 0, one LRCK falling edge -> 4 cycles after the edge oSample_L = 16'h1111, oSample_R = 16'h2222, oGrant_Valid = 1, oGrant_Idx = 0, oFrame_Strobe single pulse; oSrc_Ready[0] = 1 the following cycle.
- Mode 1 with src1 and src3 full -> frame 1 grants 1; frame 2 grants 3; frame 3 is an underrun with samples held at src3 data, oUnderrun pulse, count = 1.
- Mode 2, all four sources refilled every frame, 8 frames -> grant sequence 0,1,2,3,0,1,2,3.
- Mode 0 with iSrc_Select = 2 while src2 is empty but src0 is full -> underrun, src0 untouched; build HOLD_ON_UNDERRUN = 0 -> samples = 0.
- Mode 3 with all sources full for 3 frames -> outputs 0, no underrun, count unchanged, all oSrc_Ready = 0.
- Force count to 16'hFFFE, then 3 underruns -> count stays 16'hFFFF; iClr_Cnt coincident with an underrun -> 0. Assert iRST_N low mid-frame with sources full -> every output is at its reset value and all oSrc_Ready = 1.

Source files
------------

// File: rtl/audio_src_arbiter.sv
// Per-frame arbiter that shares the DAC serializer between up to four sample sources.
// Each source has a one-entry holding register. The winner is latched on each synchronized LRCK falling edge.

module audio_src_hold #(
    parameter int SW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_vld,
    input  logic [SW-1:0] ld_data,
    input  logic          grant,
    output logic          full,
    output logic [SW-1:0] data
);
    logic          full_q, full_d;
    logic [SW-1:0] data_q, data_d;

    // A grant only ever hits a full register and a load only an empty one,
    // so the two never collide.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (grant) begin
            full_d = 1'b0;
        end else if (ld_vld && !full_q) begin
            full_d = 1'b1;
            data_d = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign data = data_q;
endmodule

module audio_src_arbiter #(
    parameter int NUM_SRC          = 4,
    parameter int DATA_WIDTH       = 16,
    parameter bit HOLD_ON_UNDERRUN = 1'b1
) (
    input  logic                            iCLK_18_4,
    input  logic                            iRST_N,
    input  logic                            iAUD_LRCK,
    input  logic [1:0]                      iMode,
    input  logic [1:0]                      iSrc_Select,
    input  logic [NUM_SRC-1:0]              iSrc_Valid,
    output logic [NUM_SRC-1:0]              oSrc_Ready,
    input  logic [NUM_SRC*2*DATA_WIDTH-1:0] iSrc_Data,
    output logic [DATA_WIDTH-1:0]           oSample_L,
    output logic [DATA_WIDTH-1:0]           oSample_R,
    output logic                            oFrame_Strobe,
    output logic [1:0]                      oGrant_Idx,
    output logic                            oGrant_Valid,
    output logic                            oUnderrun,
    output logic [15:0]                     oUnderrun_Cnt,
    input  logic                            iClr_Cnt
);
    localparam int SW = 2 * DATA_WIDTH;

    logic [NUM_SRC-1:0]         full;
    logic [NUM_SRC-1:0]         grant_vec;
    logic [NUM_SRC-1:0][SW-1:0] hold_data;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_hold
        audio_src_hold #(.SW(SW)) u_hold (
            .clk     (iCLK_18_4),
            .rst_n   (iRST_N),
            .ld_vld  (iSrc_Valid[k]),
            .ld_data (iSrc_Data[k*SW +: SW]),
            .grant   (grant_vec[k]),
            .full    (full[k]),
            .data    (hold_data[k])
        );
    end

    assign oSrc_Ready = ~full;

    // LRCK sync chain plus edge-detect flop; the strobe is registered once more.
    logic lrck_s1_q, lrck_s2_q, lrck_s3_q, strobe_q;
    logic lrck_s1_d, lrck_s2_d, lrck_s3_d, strobe_d;

    logic [DATA_WIDTH-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
    logic                  frame_q, frame_d, gvld_q, gvld_d, undr_q, undr_d;
    logic [1:0]            gidx_q, gidx_d, rr_ptr_q, rr_ptr_d;
    logic [15:0]           undr_cnt_q, undr_cnt_d;

    logic          sel_ok;
    logic [1:0]    sel_idx;
    logic [SW-1:0] sel_data;
    int            j;

    always_comb begin
        lrck_s1_d = iAUD_LRCK;
        lrck_s2_d = lrck_s1_q;
        lrck_s3_d = lrck_s2_q;
        strobe_d  = lrck_s3_q & ~lrck_s2_q;
    end

    always_comb begin
        sel_ok  = 1'b0;
        sel_idx = 2'd0;
        j       = 0;
        case (iMode)
            2'd0: begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (iSrc_Select == 2'(k) && full[k]) begin
                        sel_ok  = 1'b1;
                        sel_idx = 2'(k);
                    end
                end
            end
            2'd1: begin
                for (int k = NUM_SRC - 1; k >= 0; k--) begin
                    if (full[k]) begin
                        sel_ok  = 1'b1;
                        sel_idx = 2'(k);
                    end
                end
            end
            2'd2: begin
                // Scan farthest-first so the nearest full source after the pointer wins.
                for (int i = NUM_SRC; i >= 1; i--) begin
                    j = (int'(rr_ptr_q) + i) % NUM_SRC;
                    if (full[j]) begin
                        sel_ok  = 1'b1;
                        sel_idx = j[1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        grant_vec = '0;
        sel_data  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (strobe_q && sel_ok && iMode != 2'd3 && sel_idx == 2'(k))
                grant_vec[k] = 1'b1;
            if (sel_idx == 2'(k))
                sel_data = hold_data[k];
        end
    end

    always_comb begin
        sample_l_d = sample_l_q;
        sample_r_d = sample_r_q;
        frame_d    = 1'b0;
        gidx_d     = gidx_q;
        gvld_d     = gvld_q;
        undr_d     = 1'b0;
        undr_cnt_d = undr_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        if (strobe_q) begin
            frame_d = 1'b1;
            if (iMode == 2'd3) begin
                sample_l_d = '0;
                sample_r_d = '0;
                gvld_d     = 1'b0;
            end else if (sel_ok) begin
                sample_l_d = sel_data[SW-1:DATA_WIDTH];
                sample_r_d = sel_data[DATA_WIDTH-1:0];
                gidx_d     = sel_idx;
                gvld_d     = 1'b1;
                if (iMode == 2'd2)
                    rr_ptr_d = sel_idx;
            end else begin
                gvld_d = 1'b0;
                undr_d = 1'b1;
                if (!HOLD_ON_UNDERRUN) begin
                    sample_l_d = '0;
                    sample_r_d = '0;
                end
                if (undr_cnt_q != 16'hFFFF)
                    undr_cnt_d = undr_cnt_q + 16'd1;
            end
        end
        if (iClr_Cnt)
            undr_cnt_d = '0;
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            lrck_s1_q  <= 1'b0;
            lrck_s2_q  <= 1'b0;
            lrck_s3_q  <= 1'b0;
            strobe_q   <= 1'b0;
            sample_l_q <= '0;
            sample_r_q <= '0;
            frame_q    <= 1'b0;
            gidx_q     <= 2'd0;
            gvld_q     <= 1'b0;
            undr_q     <= 1'b0;
            undr_cnt_q <= '0;
            rr_ptr_q   <= 2'(NUM_SRC - 1);
        end else begin
            lrck_s1_q  <= lrck_s1_d;
            lrck_s2_q  <= lrck_s2_d;
            lrck_s3_q  <= lrck_s3_d;
            strobe_q   <= strobe_d;
            sample_l_q <= sample_l_d;
            sample_r_q <= sample_r_d;
            frame_q    <= frame_d;
            gidx_q     <= gidx_d;
            gvld_q     <= gvld_d;
            undr_q     <= undr_d;
            undr_cnt_q <= undr_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign oSample_L     = sample_l_q;
    assign oSample_R     = sample_r_q;
    assign oFrame_Strobe = frame_q;
    assign oGrant_Idx    = gidx_q;
    assign oGrant_Valid  = gvld_q;
    assign oUnderrun     = undr_q;
    assign oUnderrun_Cnt = undr_cnt_q;
endmodule

// File: tb/tb_audio_src_arbiter.sv
// Scoreboard bench for audio_src_arbiter: two builds (hold / zero on underrun) share stimulus,
// expected frames are queued by the stimulus and popped by a monitor on each frame strobe.

module tb_audio_src_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         lrck = 1'b1;
    logic [1:0]   mode = 2'd0;
    logic [1:0]   sel = 2'd0;
    logic [3:0]   vld = 4'd0;
    logic [127:0] sdata = '0;
    logic         clr = 1'b0;

    logic [3:0]  rdy, rdy0;
    logic [15:0] sl, sr, sl0, sr0, uc, uc0;
    logic        fs, gv, ur, fs0, gv0, ur0;
    logic [1:0]  gi, gi0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    audio_src_arbiter #(.NUM_SRC(4), .DATA_WIDTH(16), .HOLD_ON_UNDERRUN(1'b1)) dut (
        .iCLK_18_4(clk), .iRST_N(rst_n), .iAUD_LRCK(lrck), .iMode(mode), .iSrc_Select(sel),
        .iSrc_Valid(vld), .oSrc_Ready(rdy), .iSrc_Data(sdata), .oSample_L(sl), .oSample_R(sr),
        .oFrame_Strobe(fs), .oGrant_Idx(gi), .oGrant_Valid(gv), .oUnderrun(ur),
        .oUnderrun_Cnt(uc), .iClr_Cnt(clr)
    );

    audio_src_arbiter #(.NUM_SRC(4), .DATA_WIDTH(16), .HOLD_ON_UNDERRUN(1'b0)) dut0 (
        .iCLK_18_4(clk), .iRST_N(rst_n), .iAUD_LRCK(lrck), .iMode(mode), .iSrc_Select(sel),
        .iSrc_Valid(vld), .oSrc_Ready(rdy0), .iSrc_Data(sdata), .oSample_L(sl0), .oSample_R(sr0),
        .oFrame_Strobe(fs0), .oGrant_Idx(gi0), .oGrant_Valid(gv0), .oUnderrun(ur0),
        .oUnderrun_Cnt(uc0), .iClr_Cnt(clr)
    );

    typedef struct {
        logic [15:0] l, r, l0, r0, cnt;
        logic [1:0]  idx;
        logic        chk_idx, gv, ur;
    } exp_t;

    exp_t sb[$];

    task automatic push(input logic [15:0] l, input logic [15:0] r, input logic [15:0] l0,
                        input logic [15:0] r0, input logic [1:0] idx, input logic chk_idx,
                        input logic g, input logic u, input logic [15:0] cnt);
        exp_t e;
        e.l = l; e.r = r; e.l0 = l0; e.r0 = r0; e.idx = idx; e.chk_idx = chk_idx;
        e.gv = g; e.ur = u; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame monitor: every strobe must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fs || fs0) begin
                    nvec++;
                    if (sb.size() == 0) begin
                        nerr++;
                        $display("FAIL unexpected_strobe: got strobe with empty scoreboard");
                    end else begin
                        e = sb.pop_front();
                        if (sl !== e.l || sr !== e.r || gv !== e.gv || ur !== e.ur || uc !== e.cnt ||
                            (e.chk_idx && gi !== e.idx) || sl0 !== e.l0 || sr0 !== e.r0 ||
                            gv0 !== e.gv || ur0 !== e.ur || uc0 !== e.cnt || fs !== fs0) begin
                            nerr++;
                            $display("FAIL frame: got L=%h R=%h L0=%h R0=%h idx=%0d gv=%b ur=%b cnt=%h expected L=%h R=%h L0=%h R0=%h idx=%0d(chk %b) gv=%b ur=%b cnt=%h",
                                     sl, sr, sl0, sr0, gi, gv, ur, uc, e.l, e.r, e.l0, e.r0,
                                     e.idx, e.chk_idx, e.gv, e.ur, e.cnt);
                        end
                    end
                end else if (ur || ur0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL underrun_no_strobe: got oUnderrun=1 expected 0");
                end
            end
        end
    end

    task automatic frame();
        lrck = 1'b1;
        repeat (4) @(negedge clk);
        lrck = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic load(input int k, input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        sdata[k*32 +: 32] = {l, r};
        vld[k] = 1'b1;
        @(negedge clk);
        vld = 4'd0;
    endtask

    task automatic load_all(input logic [15:0] bl, input logic [15:0] br);
        @(negedge clk);
        for (int k = 0; k < 4; k++)
            sdata[k*32 +: 32] = {bl + 16'(k), br + 16'(k)};
        vld = 4'hF;
        @(negedge clk);
        vld = 4'd0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_L"}, {sl, sr}, 32'h0);
        chk({tag, "_L0"}, {sl0, sr0}, 32'h0);
        chk({tag, "_flags"}, {fs, gv, ur, gi, fs0, gv0, ur0, gi0}, 32'h0);
        chk({tag, "_cnt"}, {uc, uc0}, 32'h0);
        chk({tag, "_ready"}, {rdy, rdy0}, 32'hFF);
    endtask

    initial begin
        int got;
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Forced select of src0 with exact latency check.
        load(0, 16'h1111, 16'h2222);
        mode = 2'd0; sel = 2'd0;
        lrck = 1'b1;
        repeat (4) @(negedge clk);
        push(16'h1111, 16'h2222, 16'h1111, 16'h2222, 2'd0, 1'b1, 1'b1, 1'b0, 16'd0);
        lrck = 1'b0;
        got = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 3) chk("ready0_before_grant", 32'(rdy[0]), 32'd0);
            if (fs && got == 0) got = c;
            if (got != 0 && c == got + 1) chk("ready0_after_grant", 32'(rdy[0]), 32'd1);
        end
        chk("strobe_latency", got, 32'd4);
        @(negedge clk);

        // Fixed priority: 1, 3, then underrun.
        load(1, 16'hA1A1, 16'hB1B1);
        load(3, 16'hA3A3, 16'hB3B3);
        mode = 2'd1;
        push(16'hA1A1, 16'hB1B1, 16'hA1A1, 16'hB1B1, 2'd1, 1'b1, 1'b1, 1'b0, 16'd0);
        frame();
        push(16'hA3A3, 16'hB3B3, 16'hA3A3, 16'hB3B3, 2'd3, 1'b1, 1'b1, 1'b0, 16'd0);
        frame();
        push(16'hA3A3, 16'hB3B3, 16'h0, 16'h0, 2'd3, 1'b1, 1'b0, 1'b1, 16'd1);
        frame();

        // Round-robin over four always-refilled sources.
        mode = 2'd2;
        for (int f = 0; f < 8; f++) begin
            load_all(16'hC000, 16'hD000);
            push(16'hC000 + 16'(f % 4), 16'hD000 + 16'(f % 4), 16'hC000 + 16'(f % 4),
                 16'hD000 + 16'(f % 4), 2'(f % 4), 1'b1, 1'b1, 1'b0, 16'd1);
            frame();
        end

        // Forced select of an empty source while src0 is full.
        mode = 2'd0; sel = 2'd2;
        push(16'hC002, 16'hD002, 16'hC002, 16'hD002, 2'd2, 1'b1, 1'b1, 1'b0, 16'd1);
        frame();
        push(16'hC002, 16'hD002, 16'h0, 16'h0, 2'd2, 1'b1, 1'b0, 1'b1, 16'd2);
        frame();
        sel = 2'd0;
        push(16'hC000, 16'hD000, 16'hC000, 16'hD000, 2'd0, 1'b1, 1'b1, 1'b0, 16'd2);
        frame();

        // Mute: nothing consumed, no underrun.
        load_all(16'hE000, 16'hF000);
        mode = 2'd3;
        for (int f = 0; f < 3; f++) begin
            push(16'h0, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd2);
            frame();
        end
        chk("mute_ready", {rdy, rdy0}, 32'h00);

        // Drain src2, then saturate and clear the counter.
        mode = 2'd0; sel = 2'd2;
        push(16'hE002, 16'hF002, 16'hE002, 16'hF002, 2'd2, 1'b1, 1'b1, 1'b0, 16'd2);
        frame();
        force dut.undr_cnt_q = 16'hFFFE;
        force dut0.undr_cnt_q = 16'hFFFE;
        #1;
        release dut.undr_cnt_q;
        release dut0.undr_cnt_q;
        for (int f = 0; f < 3; f++) begin
            push(16'hE002, 16'hF002, 16'h0, 16'h0, 2'd2, 1'b1, 1'b0, 1'b1, 16'hFFFF);
            frame();
        end
        clr = 1'b1;
        push(16'hE002, 16'hF002, 16'h0, 16'h0, 2'd2, 1'b1, 1'b0, 1'b1, 16'h0);
        frame();
        clr = 1'b0;

        // Reset mid-frame with every source full.
        load_all(16'h5000, 16'h6000);
        lrck = 1'b1;
        repeat (4) @(negedge clk);
        lrck = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
